seg7_cmd_scanner: RTL and testbench

SEG7_CMD_SCANNER -- requirements
Module: seg7_cmd_scanner

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_decode.sv | 35 +++
 rtl/seg7_cmd_scanner.sv | 165 ++++++++++++++++
 tb/tb_seg7_cmd_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants for the 6-digit command-driven 7-segment
//                scanner: command indices, reset values, segment encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Command indices carried in cmd[6:4]
  localparam logic [2:0] IDX_CTRL   = 3'd6;
  localparam logic [2:0] IDX_BLINK  = 3'd7;

  // CTRL = {dp_on_2_4, blink_en, display_en}; display on after reset
  localparam logic [2:0] CTRL_RST   = 3'b001;

  // Digit code that decodes to an unlit digit
  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int         NUM_DIGITS = 6;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] SEG_0      = 7'h40;
  localparam logic [6:0] SEG_1      = 7'h79;
  localparam logic [6:0] SEG_2      = 7'h24;
  localparam logic [6:0] SEG_3      = 7'h30;
  localparam logic [6:0] SEG_4      = 7'h19;
  localparam logic [6:0] SEG_5      = 7'h12;
  localparam logic [6:0] SEG_6      = 7'h02;
  localparam logic [6:0] SEG_7      = 7'h78;
  localparam logic [6:0] SEG_8      = 7'h00;
  localparam logic [6:0] SEG_9      = 7'h10;
  localparam logic [6:0] SEG_MINUS  = 7'h3F;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational 4-bit code to active-low 7-segment pattern.
//                0-9 numerals, A = minus sign, B-F = blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_n
);

  // Map each digit code onto its segment pattern
  always_comb begin
    seg_n = SEG_OFF;
    case (code)
      4'h0:    seg_n = SEG_0;
      4'h1:    seg_n = SEG_1;
      4'h2:    seg_n = SEG_2;
      4'h3:    seg_n = SEG_3;
      4'h4:    seg_n = SEG_4;
      4'h5:    seg_n = SEG_5;
      4'h6:    seg_n = SEG_6;
      4'h7:    seg_n = SEG_7;
      4'h8:    seg_n = SEG_8;
      4'h9:    seg_n = SEG_9;
      4'hA:    seg_n = SEG_MINUS;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_cmd_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_cmd_scanner
//  Description : Six-digit multiplexed 7-segment driver controlled by a
//                toggle-qualified command byte from an 8-bit output PIO.
//                Supports per-pair blinking, blanking and a dp on digits 2/4.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_cmd_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cmd_in,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] dig_en_n,
  output logic       cmd_ack
);

  localparam int                 SCAN_W     = $clog2(SCAN_DIV);
  localparam int                 BLINK_W    = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [7:0]         cmd_r;
  logic               tog_r;
  logic               w_event;
  logic [2:0]         w_idx;
  logic [3:0]         w_payload;

  logic [3:0]         r_digit [NUM_DIGITS];
  logic [2:0]         r_ctrl;
  logic [2:0]         r_blink_mask;
  logic               r_cmd_ack;

  logic [SCAN_W-1:0]  r_scan_cnt;
  logic [2:0]         r_scan_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  logic [3:0]         w_cur_code;
  logic               w_cur_masked;
  logic               w_cur_dp;
  logic               w_blanked;
  logic [6:0]         w_dec_seg;

  logic [6:0]         r_seg_n;
  logic               r_dp_n;
  logic [5:0]         r_dig_en_n;

  // Register the command byte and the previous toggle bit; a flip of bit 7 is one event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_r <= '0;
      tog_r <= 1'b0;
    end else begin
      cmd_r <= cmd_in;
      tog_r <= cmd_r[7];
    end
  end

  assign w_event   = cmd_r[7] ^ tog_r;
  assign w_idx     = cmd_r[6:4];
  assign w_payload = cmd_r[3:0];

  // Execute one command per toggle: digit write, CTRL write, blink mask or clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= BLANK_CODE;
      r_ctrl       <= CTRL_RST;
      r_blink_mask <= '0;
      r_cmd_ack    <= 1'b0;
    end else if (w_event) begin
      r_cmd_ack <= cmd_r[7];
      if (w_idx == IDX_CTRL) begin
        r_ctrl <= w_payload[2:0];
      end else if (w_idx == IDX_BLINK) begin
        if (w_payload[3]) begin
          for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= BLANK_CODE;
          r_ctrl       <= CTRL_RST;
          r_blink_mask <= '0;
        end else begin
          r_blink_mask <= w_payload[2:0];
        end
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (w_idx == 3'(i)) r_digit[i] <= w_payload;
        end
      end
    end
  end

  // Free-running scan and blink prescalers, independent of display/blink enables
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt    <= '0;
      r_scan_idx    <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == 3'd5) ? 3'd0 : r_scan_idx + 3'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Select the code, pair mask bit and dp eligibility of the digit being scanned
  always_comb begin
    w_cur_code   = BLANK_CODE;
    w_cur_masked = 1'b0;
    w_cur_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_scan_idx == 3'(i)) begin
        w_cur_code   = r_digit[i];
        w_cur_masked = r_blink_mask[i/2];
        w_cur_dp     = (i == 2) || (i == 4);
      end
    end
  end

  assign w_blanked = r_ctrl[1] & r_blink_phase & w_cur_masked;

  seg7_decode u_decode (
    .code  (w_cur_code),
    .seg_n (w_dec_seg)
  );

  // Registered display drive; a blinked-off digit keeps its enable asserted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_n    <= SEG_OFF;
      r_dp_n     <= 1'b1;
      r_dig_en_n <= 6'h3F;
    end else if (!r_ctrl[0]) begin
      r_seg_n    <= SEG_OFF;
      r_dp_n     <= 1'b1;
      r_dig_en_n <= 6'h3F;
    end else begin
      r_seg_n    <= w_blanked ? SEG_OFF : w_dec_seg;
      r_dp_n     <= ~(r_ctrl[2] & w_cur_dp & ~w_blanked);
      r_dig_en_n <= ~(6'b000001 << r_scan_idx);
    end
  end

  assign seg_n    = r_seg_n;
  assign dp_n     = r_dp_n;
  assign dig_en_n = r_dig_en_n;
  assign cmd_ack  = r_cmd_ack;

endmodule
`default_nettype wire

// File: tb/tb_seg7_cmd_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_cmd_scanner
//  Description : Self-checking bench for seg7_cmd_scanner with a behavioural
//                display model, directed command sequence and random commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_cmd_scanner;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 16;
  localparam int N_RAND_END = 2000;
  localparam int N_MAX      = 2100;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cmd_in  = 8'h00;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] dig_en_n;
  logic       cmd_ack;

  seg7_cmd_scanner #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_in   (cmd_in),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .dig_en_n (dig_en_n),
    .cmd_ack  (cmd_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: digit values, CTRL bits, blink mask, ack, and the last two sampled commands
  logic [3:0] m_dig [6];
  logic       m_den, m_blk, m_dp;
  logic [2:0] m_mask;
  logic       m_ack;
  logic [7:0] h1, h2;
  logic [5:0] seq [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Lit segments {g,f,e,d,c,b,a} of each glyph, inverted for the active-low pins
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] on;
    case (v)
      4'h0: on = 7'b0111111;
      4'h1: on = 7'b0000110;
      4'h2: on = 7'b1011011;
      4'h3: on = 7'b1001111;
      4'h4: on = 7'b1100110;
      4'h5: on = 7'b1101101;
      4'h6: on = 7'b1111101;
      4'h7: on = 7'b0000111;
      4'h8: on = 7'b1111111;
      4'h9: on = 7'b1101111;
      4'hA: on = 7'b1000000;
      default: on = 7'b0000000;
    endcase
    return ~on;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 6; i++) m_dig[i] = 4'hF;
    m_den  = 1'b1;
    m_blk  = 1'b0;
    m_dp   = 1'b0;
    m_mask = 3'b000;
  endtask

  task automatic m_exec(input logic [7:0] c);
    int idx;
    idx   = int'(c[6:4]);
    m_ack = c[7];
    if (idx < 6) m_dig[idx] = c[3:0];
    else if (idx == 6) begin
      m_den = c[0];
      m_blk = c[1];
      m_dp  = c[2];
    end else if (c[3]) m_clear();
    else m_mask = c[2:0];
  endtask

  // Command presented for clock edge n1: a directed prologue, then random, then display-on
  function automatic logic [7:0] stim(input int n1, input logic [7:0] cur);
    int r;
    if (n1 < 31)  return 8'h00;
    if (n1 < 36)  return 8'h83;
    if (n1 < 41)  return 8'h89;
    if (n1 < 60)  return 8'h15;
    if (n1 < 65)  return 8'hE3;
    if (n1 < 70)  return 8'h71;
    if (n1 < 200) return 8'hE7;
    if (n1 < 250) return 8'h78;
    if (n1 < N_RAND_END) begin
      r = int'($urandom_range(0, 7));
      if (r < 2)  return {~cur[7], 7'($urandom)};
      if (r == 2) return {cur[7], 7'($urandom)};
      return cur;
    end
    if (n1 == N_RAND_END) return {~cur[7], 3'd6, 4'h1};
    return cur;
  endfunction

  initial begin
    int         k, sc;
    logic       ph, blank, hit;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [5:0] e_en;

    seq[0] = 6'h3E; seq[1] = 6'h3D; seq[2] = 6'h3B;
    seq[3] = 6'h37; seq[4] = 6'h2F; seq[5] = 6'h1F;
    hit = 1'b0;
    m_clear();
    m_ack = 1'b0;
    h1 = 8'h00;
    h2 = 8'h00;

    repeat (2) @(negedge clk);
    chk("reset_seg_n",    {1'b0, seg_n}, 8'h7F);
    chk("reset_dp_n",     {7'b0, dp_n}, 8'h01);
    chk("reset_dig_en_n", {2'b0, dig_en_n}, 8'h3F);
    chk("reset_cmd_ack",  {7'b0, cmd_ack}, 8'h00);

    reset_n = 1'b1;
    cmd_in  = stim(1, 8'h00);

    for (int n = 1; n <= N_MAX; n++) begin
      @(negedge clk);
      // Display after edge n reflects the state reached at edge n-1
      k     = n - 1;
      sc    = (k / SCAN_DIV) % 6;
      ph    = ((k / BLINK_DIV) % 2) == 1;
      blank = m_blk && ph && m_mask[sc/2];
      if (!m_den) begin
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_en  = 6'h3F;
      end else begin
        e_en  = ~(6'b000001 << sc);
        e_seg = blank ? 7'h7F : seg_of(m_dig[sc]);
        e_dp  = !(!blank && m_dp && (sc == 2 || sc == 4));
      end
      // Command sampled two edges ago executes if its bit 7 differs from the one before
      if (h1[7] != h2[7]) m_exec(h1);
      h2 = h1;
      h1 = cmd_in;

      chk("seg_n",    {1'b0, seg_n}, {1'b0, e_seg});
      chk("dp_n",     {7'b0, dp_n}, {7'b0, e_dp});
      chk("dig_en_n", {2'b0, dig_en_n}, {2'b0, e_en});
      chk("cmd_ack",  {7'b0, cmd_ack}, {7'b0, m_ack});

      if (n <= 24) chk("scan_seq_lit", {2'b0, dig_en_n}, {2'b0, seq[(n-1)/4]});
      if (n == 31) chk("ack_before_lit", {7'b0, cmd_ack}, 8'h00);
      if (n == 32) chk("ack_set_lit",    {7'b0, cmd_ack}, 8'h01);
      if (n == 41) chk("ack_hold_lit",   {7'b0, cmd_ack}, 8'h01);
      if (n == 42) chk("ack_clr_lit",    {7'b0, cmd_ack}, 8'h00);
      if (n == 50) chk("digit0_lit",     {1'b0, seg_n}, 8'h30);
      if (n == 54) chk("digit1_lit",     {1'b0, seg_n}, 8'h12);

      if (n > N_RAND_END + 30 && ((n / SCAN_DIV) % 6) == 3) begin
        hit = 1'b1;
        break;
      end
      cmd_in = stim(n + 1, cmd_in);
    end

    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_point: scan index 3 not reached, got 0 expected 1");
    end

    // Assert reset between clock edges and look before any edge can occur
    #2 reset_n = 1'b0;
    #1;
    chk("async_seg_n",    {1'b0, seg_n}, 8'h7F);
    chk("async_dp_n",     {7'b0, dp_n}, 8'h01);
    chk("async_dig_en_n", {2'b0, dig_en_n}, 8'h3F);
    chk("async_cmd_ack",  {7'b0, cmd_ack}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
